// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 valid/ready data mux.
// Optional ARB_PKT_LOCK_EN keeps a grant across multi-beat packets.
module mux4_rr_arbiter #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
`ifdef ARB_PKT_LOCK_EN
    input  logic [3:0]     in_last,
`endif
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready,
    output logic [1:0]     grant,
    output logic           busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_grant;
    logic [1:0] r_ptr;

    logic [W-1:0] w_ch [4];
    logic [3:0]   w_others;
    logic         w_last;
    logic [1:0]   w_next;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        assign w_ch[g] = in_data[g*W +: W];
    end

    // First requester found scanning upward from start, wrapping mod 4.
    function automatic logic [1:0] f_pick(
        input logic [3:0] req,
        input logic [1:0] start
    );
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

`ifdef ARB_PKT_LOCK_EN
    assign w_last = in_last[r_grant];
`else
    assign w_last = 1'b1;
`endif

    assign w_next   = r_grant + 2'd1;
    assign w_others = in_valid & ~(4'b0001 << r_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_ptr   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|in_valid) begin
                        r_grant <= f_pick(in_valid, r_ptr);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_ready && w_last) begin
                        r_ptr <= w_next;
                        if (|w_others) begin
                            r_grant <= f_pick(w_others, w_next);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset masks the handshake even if the FSM is still BUSY this cycle.
    assign busy      = (r_state == BUSY);
    assign grant     = r_grant;
    assign out_valid = busy & ~rst;
    assign out_data  = out_valid ? w_ch[r_grant] : '0;
    assign in_ready  = (out_valid & out_ready) ? (4'b0001 << r_grant) : 4'b0000;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux, and the single downstream channel behind it, among four requesters.
- Each requester presents a valid/ready stream. The arbiter picks one grantee, drives the mux select from a registered grant index, and forwards the grantee's data downstream.
- The grant is held until the downstream handshake completes.
- Sits between producer channels and a shared consumer (bus, FIFO, serializer).

Parameters:
- W, 4, data width of each requester channel and of the output.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  bit i = requester i has a beat.
- in_data  input  4*W  requester i data in bits [i*W +: W].
- in_ready  output  4  bit i = beat of requester i accepted this cycle.
- out_valid  output  1  output beat present.
- out_data  output  W  muxed data of the grantee.
- out_ready  input  1  downstream accepts.
- grant  output  2  current grant index (mux select).
- busy  output  1  arbiter is in state BUSY.

Behaviour:
- Source rule: once in_valid[i] is asserted, requester i holds in_valid[i] high and in_data stable until in_ready[i] is high.
- States:
  - IDLE: no grant.
  - BUSY: grant valid.
- Registers:
  - state
  - grant (2b)
  - ptr (2b): highest-priority index for the next arbitration.
- Reset, applied while rst is high at posedge:
  - state=IDLE, grant=0, ptr=0.
  - out_valid=0, in_ready=0, out_data=0, busy=0.
  - While rst is high, out_valid and in_ready are forced to 0 regardless of state. A transfer in flight when reset asserts is dropped; no handshake is reported.
- Round-robin pick: winner = the first index k, starting at ptr and incrementing mod 4, with the request bit set.
- IDLE:
  - If |in_valid, then grant <= pick(in_valid) and state <= BUSY.
  - Latency: out_valid rises exactly 1 cycle after the first in_valid.
- BUSY combinational outputs:
  - out_valid=1.
  - out_data=in_data[grant].
  - in_ready[grant]=out_ready; all other in_ready bits are 0.
- BUSY, no handshake (out_ready=0): hold grant and state. out_data stays stable because the source holds its data.
- BUSY, handshake (out_ready=1):
  - ptr <= grant+1 (wraps 3->0).
  - Let others = in_valid with bit[grant] cleared.
  - If |others: grant <= pick(others) from ptr=grant+1 and stay BUSY. This gives back-to-back transfers with no bubble.
  - Otherwise: state <= IDLE. A re-request by the same grantee then costs one idle cycle.
- IDLE outputs: out_valid=0, out_data=0, grant holds its last value, busy=0.
- Fairness: with all four requesting continuously, grants cycle 0,1,2,3,0… A requester waits at most 3 transfers.
- Requester valid deasserting while not granted: ignored, because the pick uses the current in_valid.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- When defined:
  - Adds input port in_last (4 bits); bit i marks the final beat of requester i's packet.
  - On handshake with in_last[grant]=0: stay BUSY with the same grant, and ptr is not updated.
  - Re-arbitration and the ptr update happen only on a handshake with in_last[grant]=1.
  - Multi-beat packets are never interleaved.
- When undefined:
  - No in_last port.
  - Every beat is a complete packet, with the behaviour above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, in_ready=0, out_data=0. On the first cycle after rst=0, out_valid=0 and grant=0. On the next cycle, out_valid=1 and out_data=d0.
- Single requester: in_valid=4'b0100, data2=4'hA, out_ready=1 -> 1 cycle later out_valid=1, grant=2, out_data=4'hA, in_ready=4'b0100. The next cycle returns to IDLE.
- Full round robin: in_valid=4'b1111 held, d0..d3=4'h1,4'h2,4'h3,4'h4, out_ready=1 -> out_data sequence 1,2,3,4,1,… with one beat per cycle and no bubbles after the first.
- Backpressure: granted requester 1, out_ready=0 for 3 cycles -> grant=1 stable, out_data stable, in_ready=0. Then raise out_ready -> exactly one handshake on in_ready[1].
- Wrap and skip: ptr=3, in_valid=4'b0011 -> grant=0 then 1. A late in_valid[3] arriving during grant 0 is served after 1.
- Mid-transfer reset: BUSY with out_ready=0, pulse rst for 1 cycle -> out_valid=0 and in_ready=0 in that cycle; afterwards state=IDLE and ptr=0.
